robertson_dp: RTL and testbench
===============================

Name: robertson_dp

Overview:
- Datapath of the Robertson signed (two's-complement) multiplier.
- Sits directly downstream of the Robertson control unit (`cu`).
  - Consumes the CU's 8-bit control word `c[7:0]`.
  - Returns the status flags `q0` and `count` that the CU branches on.
- Holds the multiplicand `M`, multiplier/low-product `Q`, high-product `A`, sign-extension bit `F` and the iteration counter `CNT`.
- Operands and both product halves share a single `inbus`/`outbus` pair.

Parameters:
- `N`, default 8, operand width in bits; legal range 2..32.
- `CW`, default `$clog2(N)`, width of `CNT`.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous reset, active-high.
- `c`  input  8  control word from the CU; bit meanings are listed under Behaviour.
- `inbus`  input  N  operand input bus.
- `outbus`  output  N  registered result bus.
- `q0`  output  1  `Q[0]`, combinational from the register.
- `count`  output  1  high when `CNT == N-1`, combinational.

Behaviour:
- Reset: when `rst` is high, `A`, `Q`, `M`, `F`, `CNT` and `outbus` all go to 0 immediately, without waiting for `clk`.
  - Consequently `q0` = 0 and `count` = 0 during reset (`N` >= 2).
  - Reset asserted mid-multiplication aborts the operation; no partial state survives.
- Control bits (all take effect on the same `clk` edge):
  - `c[0]` INIT: `A`←0, `F`←0, `CNT`←0, `Q`←`inbus`.
  - `c[1]` LOADM: `M`←`inbus`.
  - `c[2]` ADD: `{F,A}` ← `{F,A}` + `{M[N-1],M}`, computed in N+1 bits with the carry out discarded.
  - `c[3]` SHIFT: `A` ← `{F, A[N-1:1]}`, `Q` ← `{A[0], Q[N-1:1]}`, `F` unchanged (arithmetic right shift of `F:A:Q`).
  - `c[4]` INC: `CNT` ← `CNT`+1, wrapping modulo 2^`CW`.
  - `c[5]` SUB (final correction): `{F,A}` ← `{F,A}` − `{M[N-1],M}`, computed in N+1 bits.
  - `c[6]` OUTA: `outbus` ← `A`.
  - `c[7]` OUTQ: `outbus` ← `Q`.
- Width rule: `{F,A}` never overflows N+1 bits for any operand pair, including −2^(N-1) × −2^(N-1).
- Expected CU sequence:
  - INIT, then LOADM.
  - N−1 iterations of: (ADD if `q0`), SHIFT, INC. `count` goes high after the (N−1)th INC.
  - Then (SUB if `q0`), SHIFT.
  - Then OUTA, OUTQ.
  - Result: `{A,Q}` = signed 2N-bit product.
- Priority and simultaneous events:
  - For `A`/`F`: `c[0]` > `c[2]`/`c[5]` > `c[3]`.
  - For `Q`: `c[0]` > `c[3]`.
  - For `CNT`: `c[0]` > `c[4]`.
  - `c[1]` is independent of all other bits.
  - `c[2]` & `c[5]` together: `A` and `F` hold (illegal word; assertion fires in simulation).
  - `c[6]` & `c[7]` together: `outbus` holds (illegal word; assertion fires).
  - `c` = 0: all state holds.
- Latency: register updates are visible one cycle after the control bit is sampled; `q0` and `count` reflect the new state in that same cycle.
- `outbus` holds its last value until the next OUTA or OUTQ.

Decomposition:
- `robertson_pkg` (shared with `cu`) contains:
  - Default `N`.
  - Localparams for the control bit indices: `C_INIT`=0, `C_LOADM`=1, `C_ADD`=2, `C_SHIFT`=3, `C_INC`=4, `C_SUB`=5, `C_OUTA`=6, `C_OUTQ`=7.
  - A typedef `ctrl_t` = `logic [7:0]`.
- One sub-module, `robertson_addsub`:
  - Interface: (N+1)-bit adder/subtractor with inputs `x`, `y`, `sub`; output `sum`.
  - Instantiated once; it serves both ADD and SUB.

Test Plan:
- Positive × positive: `N`=8, `Q`=0x05, `M`=0x03, full sequence → OUTA gives 0x00, OUTQ gives 0x0F.
- Mixed signs: `Q`=0x07, `M`=0xFD (−3) → `outbus` 0xFF then 0xEB (−21); check `F`=1 during the iterations.
- Negative multiplier (exercises SUB): `Q`=0xFD, `M`=0x07 → `q0`=1 at the correction step; result 0xFF / 0xEB.
- Corner case: `Q`=0x80, `M`=0x80 → result 0x40 / 0x00 with no overflow.
- `count` and wrap:
  - After INIT, issue INC ×6 → `count`=0.
  - 7th INC → `count`=1.
  - 8th INC → `CNT` wraps to 0, `count`=0.
- Reset and illegal words:
  - Assert `rst` between clock edges mid-iteration → all registers and `outbus` read 0 immediately.
  - `c` = 0x24 (ADD+SUB) → `A`/`F` unchanged.
  - `c` = 0xC0 → `outbus` unchanged.

Source files
------------

// File: rtl/robertson_pkg.sv
// Shared definitions for the Robertson signed multiplier: the default operand
// width and the control word layout used by both the CU and the datapath.
package robertson_pkg;

  // Default operand width in bits.
  localparam int N_DEFAULT = 8;

  // Bit positions inside the 8-bit control word.
  localparam int C_INIT  = 0;
  localparam int C_LOADM = 1;
  localparam int C_ADD   = 2;
  localparam int C_SHIFT = 3;
  localparam int C_INC   = 4;
  localparam int C_SUB   = 5;
  localparam int C_OUTA  = 6;
  localparam int C_OUTQ  = 7;

  typedef logic [7:0] ctrl_t;

endpackage : robertson_pkg

// File: rtl/robertson_addsub.sv
// W-bit adder/subtractor shared by the ADD and SUB (final correction) steps.
// Subtraction is done as x + ~y + 1 so a single carry chain serves both.
module robertson_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] y_eff;

  // Conditionally invert y; the carry-in completes the two's complement.
  always_comb begin
    y_eff = y ^ {W{sub}};
    sum   = x + y_eff + W'(sub);
  end

endmodule : robertson_addsub

// File: rtl/robertson_dp.sv
// Datapath of the Robertson signed multiplier. Holds M, Q, A, the sign
// extension bit F and the iteration counter; every register update is driven
// by one bit of the control word coming from the CU.
module robertson_dp
  import robertson_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  ctrl_t        c,
  input  logic [N-1:0] inbus,
  output logic [N-1:0] outbus,
  output logic         q0,
  output logic         count
);

  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic          f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_q, out_d;

  logic [N:0]    fa_sum;
  logic          do_add, do_sub;

  assign do_add = c[C_ADD];
  assign do_sub = c[C_SUB];

  // {F,A} +/- sign-extended M, computed in N+1 bits so the product never
  // overflows, even for the most-negative times most-negative operand pair.
  robertson_addsub #(
    .W (N + 1)
  ) u_addsub (
    .x   ({f_q, a_q}),
    .y   ({m_q[N-1], m_q}),
    .sub (do_sub),
    .sum (fa_sum)
  );

  // Next-state logic: INIT wins over arithmetic, arithmetic wins over SHIFT.
  // NOTE: every output of this block gets a hold value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    a_d   = a_q;
    f_d   = f_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    out_d = out_q;

    if (c[C_INIT]) begin
      a_d   = '0;
      f_d   = 1'b0;
      q_d   = inbus;
      cnt_d = '0;
    end else begin
      // ADD and SUB together is an illegal word: A and F simply hold.
      if (do_add || do_sub) begin
        if (do_add ^ do_sub) begin
          {f_d, a_d} = fa_sum;
        end
      end else if (c[C_SHIFT]) begin
        a_d = {f_q, a_q[N-1:1]};
      end

      if (c[C_SHIFT]) begin
        q_d = {a_q[0], q_q[N-1:1]};
      end

      if (c[C_INC]) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (c[C_LOADM]) begin
      m_d = inbus;
    end

    // OUTA and OUTQ together is an illegal word: the bus holds.
    if (c[C_OUTA] ^ c[C_OUTQ]) begin
      out_d = c[C_OUTA] ? a_q : q_q;
    end
  end

  // State registers with asynchronous clear; reset aborts any multiplication.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      f_q   <= 1'b0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      f_q   <= f_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign outbus = out_q;
  assign q0     = q_q[0];
  assign count  = (cnt_q == CW'(N - 1));

  // Flag illegal control words from the CU in simulation.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(c[C_ADD] && c[C_SUB]))
        else $warning("robertson_dp: illegal control word, ADD and SUB together");
      assert (!(c[C_OUTA] && c[C_OUTQ]))
        else $warning("robertson_dp: illegal control word, OUTA and OUTQ together");
    end
  end

endmodule : robertson_dp

// File: tb/tb_robertson_dp.sv
// Self-checking bench for robertson_dp (N = 8). The bench plays the CU role,
// and checks results against signed arithmetic computed directly from the
// operands.
module tb_robertson_dp;
  import robertson_pkg::*;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  ctrl_t        c;
  logic [N-1:0] inbus;
  logic [N-1:0] outbus;
  logic         q0;
  logic         count;

  int passed;
  int total;

  robertson_dp #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .c      (c),
    .inbus  (inbus),
    .outbus (outbus),
    .q0     (q0),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam ctrl_t W_INIT  = ctrl_t'(1 << C_INIT);
  localparam ctrl_t W_LOADM = ctrl_t'(1 << C_LOADM);
  localparam ctrl_t W_ADD   = ctrl_t'(1 << C_ADD);
  localparam ctrl_t W_SHIFT = ctrl_t'(1 << C_SHIFT);
  localparam ctrl_t W_INC   = ctrl_t'(1 << C_INC);
  localparam ctrl_t W_SUB   = ctrl_t'(1 << C_SUB);
  localparam ctrl_t W_OUTA  = ctrl_t'(1 << C_OUTA);
  localparam ctrl_t W_OUTQ  = ctrl_t'(1 << C_OUTQ);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one control word for one clock; outputs are sampled 1 ns after the edge.
  task automatic step(input ctrl_t cw, input logic [N-1:0] din);
    @(negedge clk);
    c     = cw;
    inbus = din;
    @(posedge clk);
    #1;
    c     = '0;
  endtask

  // Full CU sequence for one operand pair, checked against signed arithmetic.
  // F after each iteration is the sign of the partial product M * Q[i:0].
  task automatic run_mult(input logic [N-1:0] qv, input logic [N-1:0] mv);
    logic signed [N-1:0]   sq, sm;
    logic signed [2*N-1:0] prod;
    logic [N-1:0]          low_bits;
    sq   = qv;
    sm   = mv;
    prod = sq * sm;

    step(W_INIT, qv);
    step(W_LOADM, mv);
    check("init_count", count, 1'b0);
    for (int i = 0; i < N - 1; i++) begin
      check("q0_iter", q0, qv[i]);
      if (qv[i]) step(W_ADD, '0);
      step(W_SHIFT | W_INC, '0);
      check("count_iter", count, (i == N - 2));
      low_bits = qv & ((N'(1) << (i + 1)) - N'(1));
      check("f_iter", dut.f_q, mv[N-1] && (low_bits != '0));
    end
    check("q0_corr", q0, qv[N-1]);
    if (qv[N-1]) step(W_SUB, '0);
    step(W_SHIFT, '0);
    check("f_final", dut.f_q, prod[2*N-1]);
    step(W_OUTA, '0);
    check("outa", outbus, prod[2*N-1:N]);
    step(W_OUTQ, '0);
    check("outq", outbus, prod[N-1:0]);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    c      = '0;
    inbus  = '0;

    // Reset state.
    #2;
    check("rst_outbus", outbus, '0);
    check("rst_q0", q0, 1'b0);
    check("rst_count", count, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operand pairs.
    run_mult(8'h05, 8'h03);
    run_mult(8'h07, 8'hFD);
    run_mult(8'hFD, 8'h07);
    run_mult(8'h80, 8'h80);
    run_mult(8'h80, 8'h7F);
    run_mult(8'h00, 8'hFF);

    // Randomized operand pairs.
    for (int k = 0; k < 24; k++) begin
      run_mult(N'($urandom), N'($urandom));
    end

    // Counter: INC x6 -> 0, 7th -> 1, 8th wraps to 0.
    step(W_INIT, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step(W_INC, '0);
      check("count_wrap", count, (i == 7));
    end
    check("cnt_wrapped", dut.cnt_q, 0);

    // Illegal ADD+SUB: A and F keep the value from a single legal ADD.
    step(W_INIT, 8'h01);
    step(W_LOADM, 8'hFD);
    step(W_ADD, '0);
    check("add_a", dut.a_q, 8'hFD);
    step(W_ADD | W_SUB, '0);
    check("addsub_a_hold", dut.a_q, 8'hFD);
    check("addsub_f_hold", dut.f_q, 1'b1);

    // Illegal OUTA+OUTQ and c = 0: the bus holds the last OUTQ result.
    run_mult(8'h05, 8'h03);
    step(W_OUTA | W_OUTQ, '0);
    check("outaq_hold", outbus, 8'h0F);
    step('0, 8'hAA);
    check("idle_hold", outbus, 8'h0F);
    check("idle_q0", q0, 1'b1);

    // Asynchronous reset between edges in the middle of a multiplication.
    step(W_INIT, 8'hFF);
    step(W_LOADM, 8'h93);
    step(W_ADD, '0);
    step(W_SHIFT | W_INC, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_outbus", outbus, '0);
    check("arst_q0", q0, 1'b0);
    check("arst_count", count, 1'b0);
    check("arst_a", dut.a_q, '0);
    check("arst_q", dut.q_q, '0);
    check("arst_m", dut.m_q, '0);
    check("arst_f", dut.f_q, 1'b0);
    check("arst_cnt", dut.cnt_q, 0);
    @(negedge clk);
    rst = 1'b0;

    // Normal operation after the aborted run.
    run_mult(8'hFB, 8'hFB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_robertson_dp
